// File: rtl/zero_check_arbiter_if.sv
// ---------------------------------------------------------------------------
// zero_check_arbiter_if
// Request/response bundle for zero_check_arbiter.
//   req_valid  [NUM_REQ]                  per-requester operand valid
//   req_data   [NUM_REQ*REGISTER_LENGTH]  packed operands, req k at [k*RL +: RL]
//   req_ready  [NUM_REQ]                  one-hot grant/accept from the arbiter
//   rsp_valid  [1]                        response valid
//   rsp_ready  [1]                        response consumer ready
//   rsp_id     [ID_W]                     requester being answered
//   rsp_zero   [1]                        1 iff the accepted operand was zero
// Modports: master = requesters + response consumer, slave = arbiter.
// ---------------------------------------------------------------------------
interface zero_check_arbiter_if #(
    parameter int unsigned REGISTER_LENGTH = 64,
    parameter int unsigned NUM_REQ         = 2
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*REGISTER_LENGTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [ID_W-1:0]                    rsp_id;
    logic                               rsp_zero;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_zero
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_zero
    );
endinterface

// File: rtl/zero_check_arbiter.sv
// ---------------------------------------------------------------------------
// zero_check_arbiter
// Shares one zero checker between NUM_REQ requesters. One operand is accepted
// at a time (round-robin grant), registered, reduced to a zero flag and
// returned tagged with the requester id. Accept -> response valid is 2 cycles;
// a new operand is only accepted once the previous response was taken.
// Ports:
//   clk_i    clock, rising edge
//   reset_i  synchronous, active-high reset
//   bus      zero_check_arbiter_if.slave (request and response channels)
// Build option: define ZCA_FIXED_PRIORITY_EN for fixed priority (lowest
// valid index wins, no rotation pointer). Undefined = round-robin.
// ---------------------------------------------------------------------------
module zero_check_arbiter #(
    parameter int unsigned REGISTER_LENGTH = 64,
    parameter int unsigned NUM_REQ         = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    zero_check_arbiter_if.slave bus
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEval = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [REGISTER_LENGTH-1:0] op_q;
    logic [ID_W-1:0]            id_q;
    logic                       rsp_valid_q;
    logic [ID_W-1:0]            rsp_id_q;
    logic                       rsp_zero_q;

    logic                       found;
    logic [ID_W-1:0]            grant_idx;
    logic [ID_W:0]              cand;
    logic [REGISTER_LENGTH-1:0] grant_data;

`ifndef ZCA_FIXED_PRIORITY_EN
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_next;

    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
`endif

    // Search for the first valid requester, starting at the rotation pointer
    // (round-robin) or at 0 (fixed priority). cand is one bit wider so the
    // wrap past NUM_REQ-1 can be detected for non-power-of-two NUM_REQ.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef ZCA_FIXED_PRIORITY_EN
            cand = (ID_W + 1)'(i);
`else
            cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
            if (cand >= (ID_W + 1)'(NUM_REQ)) begin
                cand = cand - (ID_W + 1)'(NUM_REQ);
            end
`endif
            if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                grant_data = bus.req_data[k*REGISTER_LENGTH +: REGISTER_LENGTH];
            end
        end
    end

    // Grant is combinational and only offered in IDLE outside reset.
    always_comb begin
        bus.req_ready = '0;
        if (state_q == StIdle && !reset_i && found) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (found) state_d = StEval;
            StEval:  state_d = StResp;
            StResp:  if (rsp_valid_q && bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            op_q        <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_zero_q  <= 1'b0;
`ifndef ZCA_FIXED_PRIORITY_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (found) begin
                        op_q     <= grant_data;
                        id_q     <= grant_idx;
`ifndef ZCA_FIXED_PRIORITY_EN
                        rr_ptr_q <= rr_ptr_next;
`endif
                    end
                end
                StEval: begin
                    rsp_zero_q  <= ~|op_q;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_zero  = rsp_zero_q;
endmodule

// File: tb/tb_zero_check_arbiter.sv
module tb_zero_check_arbiter;
    localparam int unsigned RL = 64;
    localparam int unsigned NR = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    zero_check_arbiter_if #(.REGISTER_LENGTH(RL), .NUM_REQ(NR)) bus ();

    zero_check_arbiter #(.REGISTER_LENGTH(RL), .NUM_REQ(NR)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    typedef struct packed {
        logic id;
        logic zero;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   model_ptr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference grant choice: first valid index from the rotation start.
    function automatic int exp_grant(input logic [1:0] m);
        int start;
`ifdef ZCA_FIXED_PRIORITY_EN
        start = 0;
`else
        start = model_ptr;
`endif
        for (int i = 0; i < 2; i++) begin
            int c;
            c = (start + i) % 2;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int g);
        logic [1:0] r;
        r = 2'b00;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic note_grant(input int g);
`ifndef ZCA_FIXED_PRIORITY_EN
        model_ptr = (g + 1) % 2;
`endif
    endtask

    // Wait (bounded) for rsp_valid, checking req_ready stays low meanwhile.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check("ready_busy", 64'(bus.req_ready), 64'(2'b00));
        end while (!bus.rsp_valid && lat < 6);
        check("latency", 64'(lat), 64'(2));
    endtask

    // One full transaction; called at a negedge while the DUT is idle.
    task automatic txn(input logic [1:0] m, input logic [63:0] d0, input logic [63:0] d1,
                       input bit early);
        int   g;
        int   lat;
        exp_t e;
        bus.req_valid = m;
        bus.req_data  = {d1, d0};
        bus.rsp_ready = early;
        #1;
        g = exp_grant(m);
        check("grant", 64'(bus.req_ready), 64'(onehot(g)));
        if (g < 0) return;
        e.id   = g[0];
        e.zero = (((g == 0) ? d0 : d1) == 64'd0);
        sb.push_back(e);
        note_grant(g);
        wait_rsp(lat);
        if (bus.rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
            check("rsp_zero", 64'(bus.rsp_zero), 64'(e.zero));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_drop", 64'(bus.rsp_valid), 64'(1'b0));
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   g;
        int   lat;
        exp_t e;

        reset         = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check("rst_rsp_id", 64'(bus.rsp_id), 64'(1'b0));
        check("rst_rsp_zero", 64'(bus.rsp_zero), 64'(1'b0));
        bus.req_valid = 2'b01;
        #1;
        check("rst_ready_forced", 64'(bus.req_ready), 64'(2'b00));
        @(negedge clk);
        reset = 1'b0;

        // Basic accept of a zero operand from requester 0.
        txn(2'b01, 64'h0, 64'h0, 1'b0);

        // Requester 1 alone: MSB, bit 0, all-zero.
        txn(2'b10, 64'hFFFF, 64'h8000_0000_0000_0000, 1'b0);
        txn(2'b10, 64'hFFFF, 64'h1, 1'b0);
        txn(2'b10, 64'hFFFF, 64'h0, 1'b0);

        // Both valid, consumer always ready (also ready before rsp_valid).
        for (int k = 0; k < 4; k++) txn(2'b11, 64'h0, 64'h5, 1'b1);

        // Back-pressure: response must hold for 5 stalled cycles.
        bus.req_valid = 2'b11;
        bus.req_data  = {64'h5, 64'h0};
        bus.rsp_ready = 1'b0;
        #1;
        g = exp_grant(2'b11);
        check("bp_grant", 64'(bus.req_ready), 64'(onehot(g)));
        e.id   = g[0];
        e.zero = (g == 0);
        sb.push_back(e);
        note_grant(g);
        wait_rsp(lat);
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.rsp_valid), 64'(1'b1));
            check("bp_id", 64'(bus.rsp_id), 64'(e.id));
            check("bp_zero", 64'(bus.rsp_zero), 64'(e.zero));
            check("bp_ready", 64'(bus.req_ready), 64'(2'b00));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'(bus.rsp_valid), 64'(1'b0));
        bus.rsp_ready = 1'b0;

        // Reset while evaluating: transaction dropped, pointer back to 0.
        bus.req_valid = 2'b11;
        bus.req_data  = {64'h5, 64'h0};
        #1;
        g = exp_grant(2'b11);
        check("rst_eval_grant", 64'(bus.req_ready), 64'(onehot(g)));
        note_grant(g);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_eval_ready", 64'(bus.req_ready), 64'(2'b00));
        @(negedge clk);
        reset         = 1'b0;
        bus.req_valid = 2'b00;
        model_ptr     = 0;
        #1;
        check("post_rst_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check("post_rst_id", 64'(bus.rsp_id), 64'(1'b0));
        check("post_rst_zero", 64'(bus.rsp_zero), 64'(1'b0));
        check("post_rst_ready", 64'(bus.req_ready), 64'(2'b00));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_ghost_rsp", 64'(bus.rsp_valid), 64'(1'b0));
        end
        txn(2'b11, 64'h0, 64'h5, 1'b0);

        // Priority behaviour with both held, then requester 0 withdrawn.
        txn(2'b11, 64'h0, 64'h5, 1'b1);
        txn(2'b11, 64'h0, 64'h5, 1'b1);
        txn(2'b11, 64'h0, 64'h5, 1'b1);
        txn(2'b10, 64'h0, 64'h5, 1'b1);

        // Requester 0 single-bit boundaries.
        txn(2'b01, 64'h1, 64'h0, 1'b0);
        txn(2'b01, 64'h8000_0000_0000_0000, 64'h0, 1'b0);

        bus.req_valid = 2'b00;
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
